// File: rtl/mem_responder.sv
// Word-addressed data-memory responder with a valid/ready request channel, fixed access latency,
// one outstanding request and error flagging for misaligned or out-of-range accesses.
module mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [31:0] LIMIT    = 32'(4 * DEPTH);
    localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [31:0]   mem_q [DEPTH];

    logic          handshake_s;
    logic          commit_s;
    logic          c_we_s;
    logic [31:0]   c_addr_s;
    logic [31:0]   c_wdata_s;
    logic          c_err_s;
    logic [AW-1:0] c_idx_s;

    assign req_ready   = (state_q == ST_IDLE) && !reset;
    assign busy        = (state_q != ST_IDLE) && !reset;
    assign resp_valid  = (state_q == ST_RESP) && !reset;
    assign resp_rdata  = rdata_q;
    assign resp_err    = err_q;
    assign handshake_s = req_valid && req_ready;

    // With LATENCY==1 the commit edge is the accept edge, so the live request is committed.
    always_comb begin
        if (state_q == ST_IDLE) begin
            c_we_s    = req_we;
            c_addr_s  = req_addr;
            c_wdata_s = req_wdata;
        end else begin
            c_we_s    = we_q;
            c_addr_s  = addr_q;
            c_wdata_s = wdata_q;
        end
        c_err_s = (c_addr_s[1:0] != 2'b00) || (c_addr_s >= LIMIT);
        c_idx_s = c_addr_s[AW+1:2];
    end

    // Next-state and commit decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        commit_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (handshake_s) begin
                    if (LATENCY == 1) begin
                        state_d  = ST_RESP;
                        commit_s = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d  = ST_RESP;
                    commit_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state, latched request and registered response.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (handshake_s) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (commit_s) begin
                err_q   <= c_err_s;
                rdata_q <= (c_err_s || c_we_s) ? 32'd0 : mem_q[c_idx_s];
            end
        end
    end

    // Storage array is not reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clock) begin
        if (!reset && commit_s && c_we_s && !c_err_s) begin
            mem_q[c_idx_s] <= c_wdata_s;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed requests push expected responses into a queue,
// a monitor pops and compares on every resp_valid pulse.
module tb_mem_responder;

    localparam int LAT = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;

    logic        sw_valid;
    logic        l1_ready, l1_rv, l1_err, l1_busy;
    logic [31:0] l1_rdata;
    logic        l15_ready, l15_rv, l15_err, l15_busy;
    logic [31:0] l15_rdata;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   resp_seen = 0;
    exp_t exp_q[$];

    bit   sw_on = 1'b0;
    int   l1_prev = -1, l15_prev = -1, l1_n = 0, l15_n = 0;

    mem_responder #(.DEPTH(1024), .LATENCY(LAT)) u_dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
    );

    mem_responder #(.DEPTH(1024), .LATENCY(1)) u_l1 (
        .clock(clock), .reset(reset), .req_valid(sw_valid), .req_ready(l1_ready),
        .req_we(1'b1), .req_addr(32'h0000_0040), .req_wdata(32'h0000_1111),
        .resp_valid(l1_rv), .resp_rdata(l1_rdata), .resp_err(l1_err), .busy(l1_busy)
    );

    mem_responder #(.DEPTH(1024), .LATENCY(15)) u_l15 (
        .clock(clock), .reset(reset), .req_valid(sw_valid), .req_ready(l15_ready),
        .req_we(1'b1), .req_addr(32'h0000_0044), .req_wdata(32'h0000_2222),
        .resp_valid(l15_rv), .resp_rdata(l15_rdata), .resp_err(l15_err), .busy(l15_busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (resp_valid) begin
            resp_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                chk("resp_cycle", cyc, e.due);
            end
        end
    end

    // Sweep monitor: handshake spacing LATENCY+1, busy exactly when not ready, store responses clean.
    always @(negedge clock) begin
        if (sw_on) begin
            chk("l1_busy", {31'd0, l1_busy}, {31'd0, !l1_ready});
            chk("l15_busy", {31'd0, l15_busy}, {31'd0, !l15_ready});
            if (l1_ready) begin
                if (l1_prev >= 0) chk("l1_interval", cyc - l1_prev, 32'd2);
                l1_prev = cyc;
                l1_n++;
            end
            if (l15_ready) begin
                if (l15_prev >= 0) chk("l15_interval", cyc - l15_prev, 32'd16);
                l15_prev = cyc;
                l15_n++;
            end
            if (l1_rv) chk("l1_store_resp", {l1_rdata[30:0], l1_err}, 32'd0);
            if (l15_rv) chk("l15_store_resp", {l15_rdata[30:0], l15_err}, 32'd0);
        end
    end

    // acc is the index of the cycle whose closing edge performs the handshake.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input bit expect_resp,
                         output int acc);
        int k;
        exp_t e;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 50) begin
            @(negedge clock);
            k++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'd1, 32'd0);
            req_valid = 1'b0;
            acc = -1;
        end else begin
            acc = cyc;
            if (expect_resp) begin
                e.rdata = exp_rdata;
                e.err   = exp_err;
                e.due   = acc + LAT;
                exp_q.push_back(e);
            end
            @(posedge clock);
            #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            @(negedge clock);
            k++;
        end
        @(negedge clock);
        chk("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        int a0, a1, t;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        sw_valid  = 1'b0;

        // Reset for two cycles, then idle.
        repeat (2) begin
            @(posedge clock);
            @(negedge clock);
            chk("rst_ready", {31'd0, req_ready}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
            chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
            chk("rst_resp_rdata", resp_rdata, 32'd0);
        end
        reset = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        repeat (10) @(negedge clock);
        chk("idle_no_resp", resp_seen, 32'd0);

        // Latency sweep on LATENCY=1 and LATENCY=15 instances with req_valid held high.
        @(posedge clock);
        #1;
        sw_valid = 1'b1;
        sw_on    = 1'b1;
        repeat (100) @(negedge clock);
        @(posedge clock);
        #1;
        sw_on    = 1'b0;
        sw_valid = 1'b0;
        chk("l1_hs_count_ok", {31'd0, l1_n >= 45}, 32'd1);
        chk("l15_hs_count_ok", {31'd0, l15_n >= 6}, 32'd1);
        @(negedge clock);

        // Store/load round trip, back to back.
        issue(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, a0);
        issue(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, a1);
        chk("rt_accept_gap", a1 - a0, 32'd3);
        drain();

        // Error cases must not disturb the word at 0x10.
        issue(1'b1, 32'h10, 32'h55, 32'h0, 1'b0, 1'b1, t);
        issue(1'b1, 32'h13, 32'h12345678, 32'h0, 1'b1, 1'b1, t);
        issue(1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1'b1, t);
        issue(1'b0, 32'h1000, 32'h0, 32'h0, 1'b1, 1'b1, t);
        issue(1'b0, 32'h10, 32'h0, 32'h55, 1'b0, 1'b1, t);
        drain();

        // Boundary words: last and first.
        issue(1'b1, 32'hFFC, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b1, t);
        issue(1'b1, 32'h0, 32'h7, 32'h0, 1'b0, 1'b1, t);
        issue(1'b0, 32'hFFC, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b1, t);
        issue(1'b0, 32'h0, 32'h0, 32'h7, 1'b0, 1'b1, t);
        drain();

        // Reset asserted on the commit edge of a pending store drops it entirely.
        issue(1'b1, 32'h20, 32'h11111111, 32'h0, 1'b0, 1'b1, t);
        drain();
        issue(1'b1, 32'h20, 32'hCAFE0001, 32'h0, 1'b0, 1'b0, t);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_ready", {31'd0, req_ready}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        reset = 1'b0;
        #1;
        chk("midrst_ready_after", {31'd0, req_ready}, 32'd1);
        @(negedge clock);
        issue(1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0, 1'b1, t);
        issue(1'b1, 32'h20, 32'h1, 32'h0, 1'b0, 1'b1, t);
        issue(1'b0, 32'h20, 32'h0, 32'h1, 1'b0, 1'b1, t);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
